// File: rtl/mips_pkg.sv
// Shared definitions for the EX/MEM pipeline register slice.
//   DATA_W, REG_ADDR_W : default datapath and register-index widths
//   CTL_* / CTL_W      : bit positions and width of the control bundle
//                        {branch_ne (optional), branch, mem_read, mem_write,
//                         reg_write, mem_to_reg}
//   stage_state_t      : occupancy of the two-entry buffer
// Configuration macro: EX_MEM_BNE_EN adds the branch_ne control bit (MSB).
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned CTL_MEM_TO_REG = 0;
  localparam int unsigned CTL_REG_WRITE  = 1;
  localparam int unsigned CTL_MEM_WRITE  = 2;
  localparam int unsigned CTL_MEM_READ   = 3;
  localparam int unsigned CTL_BRANCH     = 4;
`ifdef EX_MEM_BNE_EN
  localparam int unsigned CTL_BRANCH_NE  = 5;
  localparam int unsigned CTL_W          = 6;
`else
  localparam int unsigned CTL_W          = 5;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> EX/MEM buffer -> MEM channel, plus flush and branch redirect.
//   master : environment side (EX producer, MEM consumer, PC logic)
//   slave  : the ex_mem_stage buffer
// Configuration macro: EX_MEM_BNE_EN (via mips_pkg::CTL_W) widens ctl_in/out_ctl.
interface ex_mem_stage_if #(
  parameter int unsigned DATA_W     = mips_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W
);

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          alu_result;
  logic                       alu_zero;
  logic [DATA_W-1:0]          store_data;
  logic [REG_ADDR_W-1:0]      dest_reg;
  logic [DATA_W-1:0]          branch_target;
  logic [mips_pkg::CTL_W-1:0] ctl_in;
  logic                       flush;

  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_alu_result;
  logic [DATA_W-1:0]          out_store_data;
  logic [REG_ADDR_W-1:0]      out_dest_reg;
  logic [mips_pkg::CTL_W-1:0] out_ctl;

  logic                       pc_src;
  logic [DATA_W-1:0]          pc_target;

  modport master (
    output in_valid, alu_result, alu_zero, store_data, dest_reg,
           branch_target, ctl_in, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data,
           out_dest_reg, out_ctl, pc_src, pc_target
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, store_data, dest_reg,
           branch_target, ctl_in, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data,
           out_dest_reg, out_ctl, pc_src, pc_target
  );

endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch decision for an instruction entering EX/MEM.
//   branch    : beq control bit
//   branch_ne : bne control bit (present only with EX_MEM_BNE_EN)
//   alu_zero  : ALU zero flag of the compare subtraction
//   taken     : redirect the PC to the branch target
// Configuration macro: EX_MEM_BNE_EN.
module branch_resolve (
  input  logic branch,
`ifdef EX_MEM_BNE_EN
  input  logic branch_ne,
`endif
  input  logic alu_zero,
  output logic taken
);

  always_comb begin
    taken = branch && alu_zero;
`ifdef EX_MEM_BNE_EN
    taken = taken || (branch_ne && !alu_zero);
`endif
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: two-entry (head + skid) buffer with ready/valid
// on both sides, flush, and a one-cycle branch redirect pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ex_mem_stage_if.slave (EX inputs, MEM outputs, flush,
//              pc_src/pc_target)
// Configuration macro: EX_MEM_BNE_EN (adds bne resolution, 6-bit ctl).
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = mips_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  ex_mem_stage_if.slave  bus
);

  stage_state_t state, state_n;

  logic accept, pop, taken, redirect;
  logic head_load_in, head_load_skid, skid_load;

  logic [DATA_W-1:0]     head_alu, head_sd, skid_alu, skid_sd;
  logic [REG_ADDR_W-1:0] head_dr, skid_dr;
  logic [CTL_W-1:0]      head_ctl, skid_ctl;

  // Handshake outputs depend on registered state only.
  assign bus.in_ready  = (state != ST_TWO);
  assign bus.out_valid = (state != ST_EMPTY);

  assign accept   = bus.in_valid && (state != ST_TWO);
  assign pop      = bus.out_ready && (state != ST_EMPTY);
  assign redirect = accept && taken && !bus.flush;

  branch_resolve u_branch_resolve (
    .branch    (bus.ctl_in[CTL_BRANCH]),
`ifdef EX_MEM_BNE_EN
    .branch_ne (bus.ctl_in[CTL_BRANCH_NE]),
`endif
    .alu_zero  (bus.alu_zero),
    .taken     (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (bus.flush) begin
      state_n = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (accept) begin
          state_n      = ST_ONE;
          head_load_in = 1'b1;
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_load_in = 1'b1;
          end else if (accept) begin
            state_n   = ST_TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          state_n        = ST_ONE;
          head_load_skid = 1'b1;
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_alu  <= '0;
      head_sd   <= '0;
      head_dr   <= '0;
      head_ctl  <= '0;
      skid_alu  <= '0;
      skid_sd   <= '0;
      skid_dr   <= '0;
      skid_ctl  <= '0;
      bus.pc_src    <= 1'b0;
      bus.pc_target <= '0;
    end else begin
      if (head_load_in) begin
        head_alu <= bus.alu_result;
        head_sd  <= bus.store_data;
        head_dr  <= bus.dest_reg;
        head_ctl <= bus.ctl_in;
      end else if (head_load_skid) begin
        head_alu <= skid_alu;
        head_sd  <= skid_sd;
        head_dr  <= skid_dr;
        head_ctl <= skid_ctl;
      end
      if (skid_load) begin
        skid_alu <= bus.alu_result;
        skid_sd  <= bus.store_data;
        skid_dr  <= bus.dest_reg;
        skid_ctl <= bus.ctl_in;
      end
      bus.pc_src <= redirect;
      if (redirect) bus.pc_target <= bus.branch_target;
    end
  end

  assign bus.out_alu_result = head_alu;
  assign bus.out_store_data = head_sd;
  assign bus.out_dest_reg   = head_dr;
  assign bus.out_ctl        = head_ctl;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of the ALU result, store data and branch target.
REQ-002 Parameter REG_ADDR_W, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the EX stage presents a valid instruction result.
REQ-006 in_ready  output  1  the stage can accept an entry this cycle.
REQ-007 alu_result  input  DATA_W  ALU result from EX.
REQ-008 alu_zero  input  1  ALU zero flag from EX; valid for the subtract operation.
REQ-009 store_data  input  DATA_W  rt value for store instructions.
REQ-010 dest_reg  input  REG_ADDR_W  write-back register index.
REQ-011 branch_target  input  DATA_W  PC+4+(imm<<2) computed in EX.
REQ-012 ctl_in  input  5  {branch, mem_read, mem_write, reg_write, mem_to_reg}.
REQ-013 flush  input  1  discards all held and incoming entries.
REQ-014 out_valid  output  1  the head entry is valid.
REQ-015 out_ready  input  1  the MEM stage consumes the head entry this cycle.
REQ-016 out_alu_result, out_store_data, out_dest_reg, out_ctl  output  widths as the inputs  head entry fields.
REQ-017 pc_src  output  1  one-cycle pulse: branch taken.
REQ-018 pc_target  output  DATA_W  target address qualified by pc_src.

Function
REQ-019 The stage SHALL be a two-entry buffer (head plus skid) with states EMPTY, ONE and TWO.
REQ-020 in_ready SHALL equal (state != TWO) and SHALL be driven only from registered state.
REQ-021 An entry SHALL be accepted on a cycle with in_valid && in_ready; it is popped on a cycle with out_valid && out_ready.
REQ-022 State transitions:
  - EMPTY: on accept, go to ONE.
  - ONE: on accept without pop, go to TWO; on pop without accept, go to EMPTY; on accept with pop, stay in ONE, and the new entry becomes head.
  - TWO: on pop, go to ONE, and the skid entry moves to head in the same edge.
REQ-023 out_valid SHALL equal (state != EMPTY); head fields SHALL be stable while out_valid && !out_ready.
REQ-024 Entries SHALL leave in acceptance order; latency from accept to out_valid SHALL be exactly 1 cycle when EMPTY.
REQ-025 The branch decision taken = branch && alu_zero SHALL be evaluated at acceptance.
REQ-026 pc_src SHALL pulse high for exactly one cycle, the cycle after acceptance, with pc_target = the captured branch_target.
REQ-027 A taken-branch entry SHALL still be buffered and passed to MEM, with its control bits unchanged.
REQ-028 flush SHALL force state EMPTY at the next edge, dropping any same-cycle accept, and SHALL suppress the pc_src pulse of a same-cycle accept.
REQ-029 Flush SHALL take priority over accept and pop; in_ready during the flush cycle SHALL follow REQ-020.
REQ-030 pc_target SHALL hold its last value when pc_src is low.

Reset
REQ-031 At rst the stage SHALL go to EMPTY: out_valid=0, in_ready=1 on the following cycle, pc_src=0, pc_target=0, all out_* data=0, out_ctl=0.
REQ-032 Reset mid-operation SHALL discard both entries and any pending pc_src pulse.
REQ-033 rst SHALL take priority over flush.

Configuration
REQ-034 Macro EX_MEM_BNE_EN:
  - Defined: ctl_in widens to 6 bits with a branch_ne MSB, and taken = (branch && alu_zero) || (branch_ne && !alu_zero); branch_ne propagates in out_ctl.
  - Undefined: ctl_in is 5 bits and only beq is resolved.

Structure
REQ-035 Shared package mips_pkg SHALL hold DATA_W, REG_ADDR_W, the ctl bit-index constants and the 3-state enum.
REQ-036 One sub-module, branch_resolve (combinational taken logic, macro-aware), SHALL be instantiated once.

Verification
REQ-037 Accept alu_result=0x0000_0010 with out_ready=1 -> out_valid=1 with out_alu_result=0x10 one cycle later, then EMPTY.
REQ-038 out_ready=0, accept 3 entries A, B, C -> A and B held, in_ready=0 from the cycle after B, C not accepted; then out_ready=1 -> A then B in order.
REQ-039 Accept branch=1, alu_zero=1, branch_target=0x0040_0020 -> pc_src=1 for 1 cycle with pc_target=0x0040_0020; with alu_zero=0 -> pc_src stays 0.
REQ-040 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no pc_src pulse.
REQ-041 rst asserted in state TWO with a pending branch -> all outputs 0, in_ready=1 the next cycle.
REQ-042 With EX_MEM_BNE_EN defined: branch_ne=1, alu_zero=0 -> pc_src pulse; with alu_zero=1 -> no pulse.
